cmplx_acc: RTL and testbench
============================

CMPLX_ACC -- requirements
Module: cmplx_acc

Interface
REQ-001 Parameter: LEN_W, default 8, width of the term-count port.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Port: clock, input, 1, rising-edge system clock.
REQ-004 Port: reset, input, 1, synchronous, active-low (0 = reset).
REQ-005 Port: start, input, 1, one-cycle pulse that begins an accumulation.
REQ-006 Port: len, input, LEN_W, number of complex terms to sum; sampled only when start is accepted.
REQ-007 Port: in_valid, input, 1, in_data carries a complex product this cycle.
REQ-008 Port: in_data, input, 64, complex product from the multiplier stage: [63:32] real, [31:0] imaginary, both 32-bit two's complement.
REQ-009 Port: out_ready, input, 1, consumer accepts out_data.
REQ-010 Port: busy, output, 1, high in ACC and DONE states.
REQ-011 Port: out_valid, output, 1, result available.
REQ-012 Port: out_data, output, 64, accumulated sum, same packing as in_data.
REQ-013 Port: ovf, output, 1, a signed overflow occurred in either lane during this accumulation.

Function
REQ-014 The block SHALL implement three states: IDLE, ACC, DONE.
REQ-015 IDLE: start=1 and len!=0 SHALL clear the accumulator and ovf, latch len into a down-counter, and move to ACC on the next edge.
REQ-016 IDLE: start=1 and len=0 SHALL move directly to DONE with out_data=0 and ovf=0 (1-cycle latency).
REQ-017 IDLE: in_valid SHALL be ignored; no accumulator change.
REQ-018 ACC: each cycle with in_valid=1 SHALL add real lanes and imaginary lanes independently, 32-bit wrap-around, and decrement the counter.
REQ-019 ACC: cycles with in_valid=0 SHALL hold accumulator and counter.
REQ-020 ACC: the edge that consumes the final term (counter=1 and in_valid=1) SHALL move to DONE; out_valid SHALL be high the following cycle with the sum including that term.
REQ-021 Lane overflow: operands of equal sign with a result of differing sign SHALL set ovf; ovf is sticky until the next accepted start or reset.
REQ-022 DONE: out_valid=1 and out_data/ovf SHALL be held stable until out_valid and out_ready are both high on the same edge; then return to IDLE.
REQ-023 start asserted in ACC or DONE SHALL be ignored (no restart, len not resampled).
REQ-024 start in the cycle that completes a DONE handshake SHALL be ignored; a new start is accepted only in IDLE.
REQ-025 in_valid in DONE SHALL be ignored; no extra terms are absorbed.
REQ-026 Throughput: one term per cycle sustained; back-to-back jobs separated by at least one IDLE cycle.

Reset
REQ-027 reset=0 at a rising edge SHALL force IDLE, accumulator=0, counter=0, out_valid=0, out_data=0, ovf=0, busy=0.
REQ-028 reset=0 during ACC or DONE SHALL abort the job; the partial sum is never presented.
REQ-029 reset SHALL take priority over start, in_valid and out_ready in the same cycle.

Structure
REQ-030 Shared package SHALL hold the state encoding (IDLE, ACC, DONE), lane field constants (RE_HI=63, RE_LO=32, IM_HI=31, IM_LO=0) and the lane width (32).
REQ-031 One sub-module cmplx_add SHALL be used: combinational two-lane 32-bit adder returning the packed sum and per-lane overflow flags.
REQ-032 All state, accumulator, counter and output registers SHALL be in cmplx_acc; expected size 120-250 lines.

Verification
REQ-033 start, len=3; terms {re=1,im=2},{3,4},{5,6} with in_valid gaps -> out_data re=9, im=12, ovf=0, out_valid one cycle after 3rd term.
REQ-034 start, len=0 -> next cycle out_valid=1, out_data=0, ovf=0; no in_data consumed.
REQ-035 len=2; terms re=0x7FFFFFFF then re=1 -> re=0x80000000, ovf=1; next job len=1, term re=5 -> re=5, ovf=0.
REQ-036 Result with out_ready=0 for 5 cycles while start and in_valid toggle -> out_data stable, state DONE held, no restart; out_ready=1 -> IDLE next cycle.
REQ-037 len=4, reset=0 after the 2nd term -> all outputs 0, IDLE; fresh job len=1, term {-1,-1} -> re=0xFFFFFFFF, im=0xFFFFFFFF.
REQ-038 Sustained run: len=255, in_valid held 1, im=1 each term -> im=255 after 255 consecutive cycles.

Source files
------------

// File: rtl/cmplx_acc_pkg.sv
// Shared definitions for the complex accumulator: state encoding, lane
// field positions and the per-lane signed overflow helper.
package cmplx_acc_pkg;

  localparam int LANE_W = 32;
  localparam int DATA_W = 64;
  localparam int RE_HI  = 63;
  localparam int RE_LO  = 32;
  localparam int IM_HI  = 31;
  localparam int IM_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's complement overflow: equal operand signs, result sign differs.
  function automatic logic lane_ovf(input logic [LANE_W-1:0] a,
                                    input logic [LANE_W-1:0] b,
                                    input logic [LANE_W-1:0] s);
    return (a[LANE_W-1] == b[LANE_W-1]) && (s[LANE_W-1] != a[LANE_W-1]);
  endfunction

endpackage

// File: rtl/cmplx_acc_add.sv
// Combinational two-lane adder: real and imaginary 32-bit lanes are added
// independently with wrap-around; each lane reports its own overflow.
module cmplx_add
  import cmplx_acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              ovf_re,
  output logic              ovf_im
);

  logic [LANE_W-1:0] re_sum_s;
  logic [LANE_W-1:0] im_sum_s;

  // Lane sums and overflow flags.
  always_comb begin
    re_sum_s = a[RE_HI:RE_LO] + b[RE_HI:RE_LO];
    im_sum_s = a[IM_HI:IM_LO] + b[IM_HI:IM_LO];
    sum      = {re_sum_s, im_sum_s};
    ovf_re   = lane_ovf(a[RE_HI:RE_LO], b[RE_HI:RE_LO], re_sum_s);
    ovf_im   = lane_ovf(a[IM_HI:IM_LO], b[IM_HI:IM_LO], im_sum_s);
  end

endmodule

// File: rtl/cmplx_acc.sv
// Complex accumulator: sums len complex terms (one per valid cycle) and
// presents the packed result with a sticky signed-overflow flag.
module cmplx_acc
  import cmplx_acc_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              ovf
);

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state_r,     state_nxt_s;
  logic [DATA_W-1:0] acc_r,       acc_nxt_s;
  logic [LEN_W-1:0]  cnt_r,       cnt_nxt_s;
  logic              ovf_r,       ovf_nxt_s;
  logic              out_valid_r, out_valid_nxt_s;
  logic [DATA_W-1:0] out_data_r,  out_data_nxt_s;
  logic              busy_r,      busy_nxt_s;

  logic [DATA_W-1:0] sum_s;
  logic              ovf_re_s;
  logic              ovf_im_s;

  cmplx_add u_add (
    .a      (acc_r),
    .b      (in_data),
    .sum    (sum_s),
    .ovf_re (ovf_re_s),
    .ovf_im (ovf_im_s)
  );

  // Next-state and next-register values; everything holds by default.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    ovf_nxt_s       = ovf_r;
    out_valid_nxt_s = out_valid_r;
    out_data_nxt_s  = out_data_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          acc_nxt_s      = {DATA_W{1'b0}};
          ovf_nxt_s      = 1'b0;
          out_data_nxt_s = {DATA_W{1'b0}};
          if (len != CNT_ZERO) begin
            cnt_nxt_s   = len;
            state_nxt_s = ST_ACC;
          end else begin
            // Empty job: result of zero is ready immediately.
            cnt_nxt_s       = CNT_ZERO;
            out_valid_nxt_s = 1'b1;
            state_nxt_s     = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          acc_nxt_s = sum_s;
          cnt_nxt_s = cnt_r - CNT_ONE;
          ovf_nxt_s = ovf_r | ovf_re_s | ovf_im_s;
          if (cnt_r == CNT_ONE) begin
            out_data_nxt_s  = sum_s;
            out_valid_nxt_s = 1'b1;
            state_nxt_s     = ST_DONE;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        acc_nxt_s       = {DATA_W{1'b0}};
        cnt_nxt_s       = CNT_ZERO;
        ovf_nxt_s       = 1'b0;
        out_valid_nxt_s = 1'b0;
        out_data_nxt_s  = {DATA_W{1'b0}};
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_ACC) || (state_nxt_s == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      acc_r       <= {DATA_W{1'b0}};
      cnt_r       <= CNT_ZERO;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ovf_r       <= ovf_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_cmplx_acc.sv
// Directed, table-driven bench for cmplx_acc with hand-computed results.
module tb_cmplx_acc;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        busy;
  logic        out_valid;
  logic [63:0] out_data;
  logic        ovf;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]       len;
    logic [3:0][63:0] terms;
    logic             gaps;
    logic [63:0]      exp_data;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[6];

  cmplx_acc #(.LEN_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ovf       (ovf)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_out_valid", {63'd0, out_valid}, 64'd0);
    check("hs_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_job(input vec_t v);
    start    = 1'b1;
    len      = v.len;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    if (v.len == 8'd0) begin
      check("len0_out_valid", {63'd0, out_valid}, 64'd1);
    end else begin
      check("acc_busy", {63'd0, busy}, 64'd1);
      check("acc_out_valid", {63'd0, out_valid}, 64'd0);
      for (int i = 0; i < int'(v.len); i++) begin
        if (v.gaps && i > 0) begin
          in_valid = 1'b0;
          in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
          tick();
        end
        in_valid = 1'b1;
        in_data  = v.terms[i];
        tick();
        in_valid = 1'b0;
      end
      check("done_out_valid", {63'd0, out_valid}, 64'd1);
    end
    check("job_data", out_data, v.exp_data);
    check("job_ovf", {63'd0, ovf}, {63'd0, v.exp_ovf});
    check("job_busy", {63'd0, busy}, 64'd1);
    handshake();
  endtask

  initial begin
    vec_t tmp;
    checks    = 0;
    failures  = 0;
    clock     = 1'b0;
    reset     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    out_ready = 1'b0;

    vecs[0] = '{8'd3, {64'd0, {32'd5, 32'd6}, {32'd3, 32'd4}, {32'd1, 32'd2}},
                1'b1, {32'd9, 32'd12}, 1'b0};
    vecs[1] = '{8'd2, {64'd0, 64'd0, {32'd1, 32'd0}, {32'h7FFF_FFFF, 32'd0}},
                1'b0, {32'h8000_0000, 32'd0}, 1'b1};
    vecs[2] = '{8'd1, {64'd0, 64'd0, 64'd0, {32'd5, 32'd0}},
                1'b0, {32'd5, 32'd0}, 1'b0};
    vecs[3] = '{8'd2, {64'd0, 64'd0, {32'd0, 32'h8000_0000}, {32'd0, 32'h8000_0000}},
                1'b1, 64'd0, 1'b1};
    vecs[4] = '{8'd0, {64'd0, 64'd0, 64'd0, 64'd0},
                1'b0, 64'd0, 1'b0};
    vecs[5] = '{8'd4, {64'd0, {32'd5, 32'd100}, {32'hFFFF_FFEC, 32'd3}, {32'd10, 32'hFFFF_FFFD}},
                1'b0, {32'hFFFF_FFFB, 32'd100}, 1'b0};

    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;

    // in_valid while idle must not start anything
    in_valid = 1'b1;
    in_data  = 64'h0000_0007_0000_0007;
    tick();
    tick();
    in_valid = 1'b0;
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_out_valid", {63'd0, out_valid}, 64'd0);
    check("idle_data", out_data, 64'd0);

    for (int k = 0; k < 6; k++) begin
      run_job(vecs[k]);
      tick();
    end

    // Result held in DONE while start/in_valid toggle, then handshake with start
    tmp = '{8'd1, {64'd0, 64'd0, 64'd0, {32'h11, 32'h22}}, 1'b0, {32'h11, 32'h22}, 1'b0};
    start = 1'b1;
    len   = tmp.len;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = tmp.terms[0];
    tick();
    for (int k = 0; k < 5; k++) begin
      start     = (k % 2 == 0);
      len       = 8'd3;
      in_valid  = (k % 2 == 1);
      in_data   = 64'h0000_0001_0000_0001;
      out_ready = 1'b0;
      tick();
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_data", out_data, tmp.exp_data);
      check("hold_busy", {63'd0, busy}, 64'd1);
    end
    in_valid  = 1'b0;
    start     = 1'b1;
    len       = 8'd1;
    out_ready = 1'b1;
    tick();
    check("hold_release_valid", {63'd0, out_valid}, 64'd0);
    check("hold_release_busy", {63'd0, busy}, 64'd0);
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    check("start_ignored_busy", {63'd0, busy}, 64'd0);

    // start during ACC must not restart the job
    start = 1'b1;
    len   = 8'd2;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = {32'd1, 32'd1};
    tick();
    in_valid = 1'b0;
    start    = 1'b1;
    len      = 8'd1;
    tick();
    start = 1'b0;
    check("acc_restart_valid", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1;
    in_data  = {32'd2, 32'd2};
    tick();
    in_valid = 1'b0;
    check("acc_restart_done", {63'd0, out_valid}, 64'd1);
    check("acc_restart_data", out_data, {32'd3, 32'd3});
    handshake();
    tick();

    // Reset mid-job aborts, with priority over other inputs
    start = 1'b1;
    len   = 8'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = {32'd100, 32'd100};
    tick();
    tick();
    reset     = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_data", out_data, 64'd0);
    check("abort_ovf", {63'd0, ovf}, 64'd0);
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("abort_idle_valid", {63'd0, out_valid}, 64'd0);
    tmp = '{8'd1, {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    run_job(tmp);
    tick();

    // Sustained 255-term run, one term per cycle
    start = 1'b1;
    len   = 8'd255;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'd1;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i == 253) check("long_early_valid", {63'd0, out_valid}, 64'd0);
    end
    in_valid = 1'b0;
    check("long_out_valid", {63'd0, out_valid}, 64'd1);
    check("long_data", out_data, 64'h0000_0000_0000_00FF);
    check("long_ovf", {63'd0, ovf}, 64'd0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
